// File: rtl/seg_display_4digit_pkg.sv
// Shared constants for the 4-digit seven-segment display: segment codes,
// converter state encoding and the BCD-nibble-to-segment encoder.
package seg_pkg;

  localparam int NUM_DIGITS = 4;

  // Common-anode codes: a segment is lit when its bit is 0; bit 7 is dp (kept off)
  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_DASH  = 8'hBF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } conv_state_e;

  function automatic logic [7:0] seg_encode(input logic [3:0] nib);
    logic [7:0] code;
    case (nib)
      4'd0:    code = SEG_0;
      4'd1:    code = SEG_1;
      4'd2:    code = SEG_2;
      4'd3:    code = SEG_3;
      4'd4:    code = SEG_4;
      4'd5:    code = SEG_5;
      4'd6:    code = SEG_6;
      4'd7:    code = SEG_7;
      4'd8:    code = SEG_8;
      4'd9:    code = SEG_9;
      default: code = SEG_DASH;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/seg_display_4digit_bin2bcd.sv
// Sequential double-dabble converter: VAL_W shift cycles plus one DONE cycle,
// result is four packed BCD nibbles.
module bin2bcd_seq
  import seg_pkg::*;
#(
  parameter int VAL_W = 14
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [VAL_W-1:0] bin,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [15:0]      bcd
);

  localparam int CNT_W = $clog2(VAL_W + 1);

  conv_state_e      state_q, state_d;
  logic [VAL_W-1:0] bin_q, bin_d;
  logic [15:0]      bcd_q, bcd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      adj;

  // Add-3 correction on every nibble that would overflow past 9 after the shift
  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < 4; i++) begin
      if (bcd_q[i*4 +: 4] >= 4'd5) adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          bin_d   = bin;
          bcd_d   = '0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        {bcd_d, bin_d} = {adj, bin_q} << 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(VAL_W - 1)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign bcd  = bcd_q;

endmodule

// File: rtl/seg_display_4digit.sv
// Four-digit multiplexed 7-segment driver: converts the binary seconds count
// to BCD on every change and scans the digits one slot at a time.
module seg_display_4digit
  import seg_pkg::*;
#(
  parameter int SCAN_DIV = 50000,
  parameter bit BLANK_LZ = 1'b1,
  parameter int VAL_W    = 14
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic [VAL_W-1:0] value,
  output logic [3:0]       seg_sel,
  output logic [7:0]       seg_led
);

  localparam int CNT_W = $clog2(SCAN_DIV);

  logic [VAL_W-1:0]          val_q, val_d;
  logic                      pend_q, pend_d;
  logic [4*NUM_DIGITS-1:0]   disp_q, disp_d;
  logic                      oor_q, oor_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [1:0]                idx_q, idx_d;
  logic [3:0]                sel_q, sel_d;
  logic [7:0]                led_q, led_d;
  logic                      start, busy, done;
  logic [15:0]               bcd;
  logic [3:0]                nib;
  logic                      upper_zero;

  // A change arriving while busy stays visible as value != val_q until IDLE
  assign start = (pend_q || (value != val_q)) && !busy;

  bin2bcd_seq #(.VAL_W(VAL_W)) u_bin2bcd (
    .clk   (sys_clk),
    .rst_n (sys_rst_n),
    .bin   (value),
    .start (start),
    .busy  (busy),
    .done  (done),
    .bcd   (bcd)
  );

  always_comb begin
    val_d  = val_q;
    pend_d = pend_q;
    disp_d = disp_q;
    oor_d  = oor_q;
    if (start) begin
      val_d  = value;
      pend_d = 1'b0;
    end
    if (done) begin
      disp_d = bcd;
      oor_d  = (32'(val_q) > 32'd9999);
    end
  end

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    idx_d = idx_q;
    if (cnt_q == CNT_W'(SCAN_DIV - 1)) begin
      cnt_d = '0;
      idx_d = idx_q + 2'd1;
    end
  end

  // Blank a digit only when it and every more significant digit are zero
  always_comb begin
    nib        = disp_q[{idx_q, 2'b00} +: 4];
    upper_zero = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if ((i >= int'(idx_q)) && (disp_q[i*4 +: 4] != 4'd0)) upper_zero = 1'b0;
    end
    sel_d = ~(4'b0001 << idx_q);
    if (oor_q)                                        led_d = SEG_DASH;
    else if (BLANK_LZ && (idx_q != 2'd0) && upper_zero) led_d = SEG_BLANK;
    else                                              led_d = seg_encode(nib);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      val_q  <= '0;
      pend_q <= 1'b1;
      disp_q <= '0;
      oor_q  <= 1'b0;
      cnt_q  <= '0;
      idx_q  <= '0;
      sel_q  <= 4'b1111;
      led_q  <= SEG_BLANK;
    end else begin
      val_q  <= val_d;
      pend_q <= pend_d;
      disp_q <= disp_d;
      oor_q  <= oor_d;
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      sel_q  <= sel_d;
      led_q  <= led_d;
    end
  end

  assign seg_sel = sel_q;
  assign seg_led = led_q;

endmodule

// File: tb/tb_seg_display_4digit.sv
// Bench for seg_display_4digit: two instances (leading-zero blanking on/off)
// compared every cycle against a decimal-arithmetic model, plus literal scan checks.
module tb_seg_display_4digit;

  localparam int D = 4;

  logic        sys_clk   = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic [13:0] value     = '0;
  logic [3:0]  sel1, sel0;
  logic [7:0]  led1, led0;
  int          n_chk  = 0;
  int          n_fail = 0;
  bit          cmp_en = 1'b0;

  always #5 sys_clk = ~sys_clk;

  seg_display_4digit #(.SCAN_DIV(D), .BLANK_LZ(1'b1), .VAL_W(14)) u_dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .value     (value),
    .seg_sel   (sel1),
    .seg_led   (led1)
  );

  seg_display_4digit #(.SCAN_DIV(D), .BLANK_LZ(1'b0), .VAL_W(14)) u_dut0 (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .value     (value),
    .seg_sel   (sel0),
    .seg_led   (led0)
  );

  task automatic checkv(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected segment code for digit k of decimal value v
  function automatic logic [7:0] digit_code(input int v, input int k, input bit blank);
    int p;
    int d;
    p = 1;
    for (int i = 0; i < k; i++) p *= 10;
    if (v > 9999) return 8'hBF;
    if (blank && (k > 0) && (v < p)) return 8'hFF;
    d = (v / p) % 10;
    case (d)
      0: return 8'hC0;
      1: return 8'hF9;
      2: return 8'hA4;
      3: return 8'hB0;
      4: return 8'h99;
      5: return 8'h92;
      6: return 8'h82;
      7: return 8'hF8;
      8: return 8'h80;
      default: return 8'h90;
    endcase
  endfunction

  // Model: edge count since release gives the slot; a conversion is a
  // 16-edge window from acceptance to display update.
  int         m_e, m_disp, m_lat, m_timer;
  bit         m_pend;
  logic [3:0] m_sel;
  logic [7:0] m_led1, m_led0;

  always @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      m_e     <= 0;
      m_disp  <= 0;
      m_lat   <= 0;
      m_timer <= 0;
      m_pend  <= 1'b1;
      m_sel   <= 4'hF;
      m_led1  <= 8'hFF;
      m_led0  <= 8'hFF;
    end else begin : model_step
      int k;
      k = (m_e / D) % 4;
      m_sel  <= ~(4'b0001 << k);
      m_led1 <= digit_code(m_disp, k, 1'b1);
      m_led0 <= digit_code(m_disp, k, 1'b0);
      m_e    <= m_e + 1;
      if (m_timer == 0) begin
        if (m_pend || (int'(value) != m_lat)) begin
          m_lat   <= int'(value);
          m_pend  <= 1'b0;
          m_timer <= 15;
        end
      end else begin
        m_timer <= m_timer - 1;
        if (m_timer == 1) m_disp <= m_lat;
      end
    end
  end

  always @(negedge sys_clk) begin
    if (cmp_en) begin
      checkv("sel_lz",   {4'h0, sel1}, {4'h0, m_sel});
      checkv("led_lz",   led1, m_led1);
      checkv("sel_nolz", {4'h0, sel0}, {4'h0, m_sel});
      checkv("led_nolz", led0, m_led0);
    end
  end

  // Collect one full scan and compare each digit slot to literal codes
  task automatic check_slots(input string name, input bit lz,
                             input logic [7:0] e0, input logic [7:0] e1,
                             input logic [7:0] e2, input logic [7:0] e3);
    logic [7:0] got [4];
    logic [7:0] exp_l [4];
    logic [3:0] s;
    logic [7:0] l;
    exp_l = '{e0, e1, e2, e3};
    got   = '{default: 8'hxx};
    for (int c = 0; c < 4 * D; c++) begin
      @(negedge sys_clk);
      s = lz ? sel1 : sel0;
      l = lz ? led1 : led0;
      for (int k = 0; k < 4; k++) if (s == ~(4'b0001 << k)) got[k] = l;
    end
    for (int k = 0; k < 4; k++) checkv($sformatf("%s_d%0d", name, k), got[k], exp_l[k]);
  endtask

  task automatic set_value(input int v, input int wait_cyc);
    @(negedge sys_clk);
    value = 14'(v);
    repeat (wait_cyc) @(negedge sys_clk);
  endtask

  task automatic release_reset();
    @(negedge sys_clk);
    #2 sys_rst_n = 1'b1;
  endtask

  initial begin
    bit saw9999;
    cmp_en = 1'b1;
    repeat (3) @(negedge sys_clk);
    checkv("rst_sel", {4'h0, sel1}, 8'h0F);
    checkv("rst_led", led1, 8'hFF);

    release_reset();
    @(negedge sys_clk);
    checkv("scan_slot0", {4'h0, sel1}, 8'h0E);
    repeat (4) @(negedge sys_clk);
    checkv("scan_slot1", {4'h0, sel1}, 8'h0D);
    repeat (4) @(negedge sys_clk);
    checkv("scan_slot2", {4'h0, sel1}, 8'h0B);

    set_value(1234, 40);
    check_slots("v1234", 1'b1, 8'h99, 8'hB0, 8'hA4, 8'hF9);
    set_value(7, 40);
    check_slots("v7_lz", 1'b1, 8'hF8, 8'hFF, 8'hFF, 8'hFF);
    check_slots("v7_nolz", 1'b0, 8'hF8, 8'hC0, 8'hC0, 8'hC0);
    set_value(0, 40);
    check_slots("v0", 1'b1, 8'hC0, 8'hFF, 8'hFF, 8'hFF);
    set_value(12000, 40);
    check_slots("v12000", 1'b1, 8'hBF, 8'hBF, 8'hBF, 8'hBF);
    set_value(9999, 32);
    check_slots("v9999", 1'b1, 8'h90, 8'h90, 8'h90, 8'h90);

    // 9999 in flight, then 0 arrives mid-shift
    set_value(1, 40);
    set_value(9999, 5);
    value   = 14'd0;
    saw9999 = 1'b0;
    for (int c = 0; c < 32; c++) begin
      @(negedge sys_clk);
      if (led1 == 8'h90) saw9999 = 1'b1;
    end
    checkv("mid_saw9999", {7'h0, saw9999}, 8'h01);
    check_slots("mid_final0", 1'b1, 8'hC0, 8'hFF, 8'hFF, 8'hFF);

    // Reset in the middle of a conversion
    set_value(5678, 6);
    #2 sys_rst_n = 1'b0;
    #1;
    checkv("midrst_sel", {4'h0, sel1}, 8'h0F);
    checkv("midrst_led", led1, 8'hFF);
    checkv("midrst_led0", led0, 8'hFF);
    repeat (2) @(negedge sys_clk);
    release_reset();
    repeat (16 + D) @(negedge sys_clk);
    check_slots("v5678", 1'b1, 8'h80, 8'hF8, 8'h82, 8'h92);

    for (int it = 0; it < 300; it++) begin
      int sel_r;
      int v;
      sel_r = $urandom_range(0, 99);
      if (sel_r < 25)      v = $urandom_range(0, 9);
      else if (sel_r < 50) v = $urandom_range(0, 9999);
      else if (sel_r < 65) v = $urandom_range(9990, 10010);
      else                 v = $urandom_range(0, 16383);
      set_value(v, $urandom_range(1, 40));
      if ($urandom_range(0, 39) == 0) begin
        #2 sys_rst_n = 1'b0;
        @(negedge sys_clk);
        release_reset();
      end
    end
    repeat (40) @(negedge sys_clk);

    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
